// File: rtl/y86_bus_pkg.sv
// Shared definitions for the Y86 bus responder.
// Holds the default memory size, the console address and the console FIFO depth.
// It also holds the console status bit positions, the address decode type and a
// helper that builds the console status word.
package y86_bus_pkg;

  localparam int unsigned MEM_BYTES_DEFAULT  = 1024;
  localparam logic [31:0] CON_ADDR_DEFAULT   = 32'h0000_FFF0;
  localparam int unsigned FIFO_DEPTH_DEFAULT = 4;

  localparam int unsigned STAT_EMPTY = 0;
  localparam int unsigned STAT_FULL  = 1;
  localparam int unsigned STAT_OVF   = 2;

  typedef enum logic [1:0] {
    DEC_NONE = 2'd0,
    DEC_MEM  = 2'd1,
    DEC_CON  = 2'd2,
    DEC_OOB  = 2'd3
  } dec_e;

  function automatic logic [31:0] con_status(input logic empty, input logic full,
                                             input logic ovf);
    logic [31:0] s;
    s             = '0;
    s[STAT_EMPTY] = empty;
    s[STAT_FULL]  = full;
    s[STAT_OVF]   = ovf;
    return s;
  endfunction

endpackage

// File: rtl/y86_con_fifo.sv
// Console output FIFO.
// Ports: clk, rst (synchronous, active-high); push_i/data_i write side;
//        pop_i read side; full_o, empty_o status; head_o = oldest entry (0 when empty).
// A push while full is accepted only if a pop happens in the same cycle.
module y86_con_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] slot_q [DEPTH];
  logic             do_push, do_pop;

  // The extra pointer MSB separates full from empty when the indices match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  assign head_o  = empty_o ? '0 : slot_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && do_push) slot_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/y86_bus_responder.sv
// Memory/console responder for a Y86 CPU bus.
// Ports: clk, rst (synchronous, active-high)
//        bus_A, bus_out, bus_RE, bus_WE  CPU address, write data and strobes
//        bus_in                          combinational read data (zero wait states)
//        ld_en, ld_addr, ld_data         byte preload port, active even in reset
//        con_data, con_valid, con_ready  console byte drain handshake
//        err_oob, err_proto, con_ovf     sticky error flags
// Memory is a little-endian byte array with wrapping indices and is never reset.
module y86_bus_responder
  import y86_bus_pkg::*;
#(
  parameter int unsigned MEM_BYTES  = MEM_BYTES_DEFAULT,
  parameter logic [31:0] CON_ADDR   = CON_ADDR_DEFAULT,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] bus_A,
  input  logic [31:0] bus_out,
  output logic [31:0] bus_in,
  input  logic        bus_RE,
  input  logic        bus_WE,
  input  logic        ld_en,
  input  logic [15:0] ld_addr,
  input  logic [7:0]  ld_data,
  output logic [7:0]  con_data,
  output logic        con_valid,
  input  logic        con_ready,
  output logic        err_oob,
  output logic        err_proto,
  output logic        con_ovf
);

  localparam int AW = $clog2(MEM_BYTES);

  logic [7:0]    mem_q [MEM_BYTES];
  logic [AW-1:0] bidx [4];
  logic [AW-1:0] ld_idx;
  dec_e          dec;
  logic          fifo_full, fifo_empty, push, pop, ovf_evt;
  logic          err_oob_q, err_oob_d;
  logic          err_proto_q, err_proto_d;
  logic          con_ovf_q, con_ovf_d;
  logic          unused_ld_hi;

  assign ld_idx       = ld_addr[AW-1:0];
  assign unused_ld_hi = |(ld_addr >> AW);

  // The console address takes priority should it ever fall inside the array.
  always_comb begin
    dec = DEC_NONE;
    if (bus_RE || bus_WE) begin
      if (bus_A == CON_ADDR)              dec = DEC_CON;
      else if (bus_A < 32'(MEM_BYTES))    dec = DEC_MEM;
      else                                dec = DEC_OOB;
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++) bidx[k] = bus_A[AW-1:0] + AW'(k);
  end

  // Read data always reflects pre-write contents, which covers RE+WE collisions.
  always_comb begin
    bus_in = '0;
    if (bus_RE && !rst) begin
      case (dec)
        DEC_MEM: bus_in = {mem_q[bidx[3]], mem_q[bidx[2]], mem_q[bidx[1]], mem_q[bidx[0]]};
        DEC_CON: bus_in = con_status(fifo_empty, fifo_full, con_ovf_q);
        default: bus_in = '0;
      endcase
    end
  end

  // Preload is issued last so it overrides a bus write to the same byte.
  always_ff @(posedge clk) begin
    if (!rst && bus_WE && dec == DEC_MEM) begin
      for (int k = 0; k < 4; k++) mem_q[bidx[k]] <= bus_out[8*k +: 8];
    end
    if (ld_en) mem_q[ld_idx] <= ld_data;
  end

  assign push    = bus_WE && !rst && (dec == DEC_CON);
  assign pop     = con_valid && con_ready;
  assign ovf_evt = push && fifo_full && !pop;

  y86_con_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_con_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  (bus_out[7:0]),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (con_data)
  );

  assign con_valid = !fifo_empty;

  always_comb begin
    err_oob_d   = err_oob_q   || (dec == DEC_OOB);
    err_proto_d = err_proto_q || (bus_RE && bus_WE);
    con_ovf_d   = con_ovf_q   || ovf_evt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_oob_q   <= 1'b0;
      err_proto_q <= 1'b0;
      con_ovf_q   <= 1'b0;
    end else begin
      err_oob_q   <= err_oob_d;
      err_proto_q <= err_proto_d;
      con_ovf_q   <= con_ovf_d;
    end
  end

  assign err_oob   = err_oob_q;
  assign err_proto = err_proto_q;
  assign con_ovf   = con_ovf_q;

endmodule

// File: doc/y86_bus_responder.md
Y86_BUS_RESPONDER -- requirements
Module: y86_bus_responder

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 1024: byte-array size, power of two.
REQ-002 SHALL have parameter CON_ADDR, default 32'h0000_FFF0: console data/status address.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: console FIFO entries, power of two.
REQ-004 SHALL have port clk, input, 1: clock; all state updates on rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port bus_A, input, 32: byte address from CPU.
REQ-007 SHALL have port bus_out, input, 32: write data from CPU.
REQ-008 SHALL have port bus_in, output, 32: read data to CPU.
REQ-009 SHALL have ports bus_RE and bus_WE, input, 1 each: read strobe and write strobe.
REQ-010 SHALL have ports ld_en (1), ld_addr (16) and ld_data (8), inputs: byte preload port.
REQ-011 SHALL have ports con_data (8) and con_valid (1), outputs; and con_ready (1), input: console drain handshake.
REQ-012 SHALL have port err_oob, output, 1: sticky flag, out-of-range access.
REQ-013 SHALL have ports err_proto and con_ovf, outputs, 1 each: sticky flags, RE+WE collision and console overflow.

Function
REQ-014 SHALL drive bus_in combinationally in the same cycle, so the CPU samples it at the next edge; reads have zero wait states.
REQ-015 SHALL return, for in-range A (A < MEM_BYTES), little-endian {mem[A+3],mem[A+2],mem[A+1],mem[A]}; byte indices wrap modulo MEM_BYTES; unaligned reads are legal.
REQ-016 SHALL return {29'b0, con_ovf, fifo_full, fifo_empty} for A == CON_ADDR.
REQ-017 SHALL return 32'h0 for any other A.
REQ-018 SHALL drive bus_in = 0 when bus_RE = 0.
REQ-019 SHALL, on bus_WE at an in-range A, write the 4 bytes of bus_out little-endian at A..A+3 (wrapped) at the clock edge.
REQ-020 SHALL, on bus_WE at A == CON_ADDR, push bus_out[7:0] into the console FIFO; no memory write occurs.
REQ-021 SHALL set err_oob when bus_RE or bus_WE is asserted at an address that is neither in range nor CON_ADDR; writes to such addresses are discarded.
REQ-022 SHALL, when bus_RE and bus_WE are both 1, set err_proto, perform the write, and drive read data from pre-write contents.
REQ-023 SHALL write ld_data to mem[ld_addr mod MEM_BYTES] when ld_en = 1, in any state including rst; the preload wins over a bus write to the same byte.
REQ-024 SHALL present the FIFO head on con_data with con_valid = !empty; a pop occurs on con_valid && con_ready.
REQ-025 SHALL accept a push when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
REQ-026 SHALL otherwise drop the pushed byte and set con_ovf.
REQ-027 SHALL, on a push into an empty FIFO, assert con_valid at the next edge (1-cycle latency); same-cycle push and pop on a non-empty FIFO leaves the count unchanged.
REQ-028 SHALL keep FIFO pointers at log2(FIFO_DEPTH)+1 bits, wrapping naturally; full and empty are derived from pointer MSB and index compare.

Reset
REQ-029 SHALL, on rst, clear the FIFO (con_valid = 0, con_data = 0), err_oob, err_proto and con_ovf.
REQ-030 SHALL ignore bus strobes during rst; memory contents are not reset.
REQ-031 SHALL discard a push coincident with rst.

Structure
REQ-032 SHALL place default MEM_BYTES, CON_ADDR, FIFO_DEPTH and the status bit positions (EMPTY=0, FULL=1, OVF=2) in shared package y86_bus_pkg.
REQ-033 SHALL implement the console FIFO as sub-module y86_con_fifo (push/pop/full/empty/head); decode and the byte array stay in the top level.

Verification
REQ-034 SHALL cover: preload bytes 0x11,0x22,0x33,0x44,0x55 at 0..4, bus_RE at A=1 -> bus_in = 32'h55443322 in the same cycle.
REQ-035 SHALL cover: bus_WE at A=MEM_BYTES-2 with bus_out = 32'hAABBCCDD -> mem[1022]=DD, mem[1023]=CC, mem[0]=BB, mem[1]=AA.
REQ-036 SHALL cover: 5 console writes 'a'..'e' with con_ready = 0 -> 4 bytes held, 'e' dropped, con_ovf = 1; status read = 32'h6.
REQ-037 SHALL cover: FIFO full with con_ready = 1 and a push in the same cycle -> push accepted, no overflow, drain order preserved.
REQ-038 SHALL cover: bus_RE at A=32'h2000 -> bus_in = 0, err_oob = 1.
REQ-039 SHALL cover: RE+WE together -> err_proto = 1; a following rst clears all flags and con_valid while preloaded memory is retained.
